// File: rtl/prog_loader.sv
// Instruction encoder/writer: packs opcode fields into 16-bit words and writes them to imem from address 0.
// Optional macro PROG_LOADER_ILLEGAL_CHECK_EN rejects opcodes 110/111 and flags them on err.
module prog_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_opcode,
    input  logic [2:0]        in_rs,
    input  logic [2:0]        in_rt,
    input  logic [2:0]        in_rd,
    input  logic [3:0]        in_funct,
    input  logic [6:0]        in_imm,
    input  logic [12:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done
`ifdef PROG_LOADER_ILLEGAL_CHECK_EN
    ,
    output logic              err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] PTR_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_LAST = (ADDR_W+1)'(DEPTH - 1);

    state_t              state_reg, state_next;
    logic [ADDR_W:0]     ptr_reg;
    logic                we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [15:0]         wdata_reg;
    logic [15:0]         word_next;
    logic                illegal;
    logic                accept;
    logic                write;

`ifdef PROG_LOADER_ILLEGAL_CHECK_EN
    logic                err_reg;
    assign illegal = in_opcode[2] & in_opcode[1];
    assign err     = err_reg;
`else
    assign illegal = 1'b0;
`endif

    assign in_ready = (state_reg == LOAD) & ~start & (ptr_reg < PTR_FULL);
    assign accept   = in_valid & in_ready;
    assign write    = accept & ~illegal;

    always_comb begin
        word_next = {in_opcode, in_rs, in_rt, in_rd, in_funct};
        case (in_opcode)
            3'b001, 3'b010, 3'b011, 3'b100: word_next = {in_opcode, in_rs, in_rt, in_imm};
            3'b101:                         word_next = {in_opcode, in_target};
            default:                        word_next = {in_opcode, in_rs, in_rt, in_rd, in_funct};
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = LOAD;
            LOAD: begin
                if (start)
                    state_next = LOAD;
                else if (accept && (in_last || (write && ptr_reg == PTR_LAST)))
                    state_next = DONE;
            end
            DONE: if (start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    // ptr advances on the same edge that raises imem_we, so it doubles as the write count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            we_reg    <= write;
            if (start)
                ptr_reg <= '0;
            else if (write)
                ptr_reg <= ptr_reg + 1'b1;
            if (write) begin
                addr_reg  <= ptr_reg[ADDR_W-1:0];
                wdata_reg <= word_next;
            end
        end
    end

`ifdef PROG_LOADER_ILLEGAL_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_reg <= 1'b0;
        else
            err_reg <= accept & illegal;
    end
`endif

    assign imem_we    = we_reg;
    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;
    assign count      = ptr_reg;
    assign busy       = (state_reg == LOAD);
    assign done       = (state_reg == DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: driver predicts writes from a field-level model, monitor checks imem writes.
module tb_prog_loader;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 20;
`ifdef PROG_LOADER_ILLEGAL_CHECK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [2:0]        in_opcode;
    logic [2:0]        in_rs;
    logic [2:0]        in_rt;
    logic [2:0]        in_rd;
    logic [3:0]        in_funct;
    logic [6:0]        in_imm;
    logic [12:0]       in_target;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
`ifdef PROG_LOADER_ILLEGAL_CHECK_EN
    logic              err;
`endif

    prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .busy(busy), .done(done)
`ifdef PROG_LOADER_ILLEGAL_CHECK_EN
        , .err(err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;
    typedef enum {M_IDLE, M_LOAD, M_DONE} mstate_t;

    wr_t     exp_q[$];
    int      n_cmp = 0;
    int      n_bad = 0;
    mstate_t mst = M_IDLE;
    int      mptr = 0;
    bit      err_pend = 1'b0;
    int      mon_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Field-level encoding from the instruction format table.
    function automatic int encode(int op, int rs, int rt, int rd, int fn, int imm, int tg);
        if (op >= 1 && op <= 4) return op * 8192 + rs * 1024 + rt * 128 + imm;
        if (op == 5)            return op * 8192 + tg;
        return op * 8192 + rs * 1024 + rt * 128 + rd * 16 + fn;
    endfunction

    task automatic step(input bit st, input bit v, input bit l, input int op, input int rs,
                        input int rt, input int rd, input int fn, input int imm, input int tg);
        bit exp_ready;
        bit acc;
        @(posedge clk);
        #1;
        start = st; in_valid = v; in_last = l;
        in_opcode = 3'(op); in_rs = 3'(rs); in_rt = 3'(rt); in_rd = 3'(rd);
        in_funct = 4'(fn); in_imm = 7'(imm); in_target = 13'(tg);
        @(negedge clk);
        exp_ready = (mst == M_LOAD) && !st && (mptr < DEPTH);
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("busy", 32'(busy), 32'(mst == M_LOAD));
        chk("done", 32'(done), 32'(mst == M_DONE));
`ifdef PROG_LOADER_ILLEGAL_CHECK_EN
        chk("err", 32'(err), 32'(err_pend));
`endif
        acc = v && exp_ready;
        err_pend = 1'b0;
        if (st) begin
            mst = M_LOAD;
            mptr = 0;
        end else if (acc) begin
            if (ILL_EN && op >= 6) begin
                err_pend = 1'b1;
            end else begin
                exp_q.push_back('{mptr, encode(op, rs, rt, rd, fn, imm, tg)});
                mptr++;
            end
            if (l || mptr == DEPTH) mst = M_DONE;
        end
    endtask

    task automatic beat(input int op, input int rs, input int rt, input int rd, input int fn,
                        input int imm, input int tg, input bit l);
        step(1'b0, 1'b1, l, op, rs, rt, rd, fn, imm, tg);
    endtask

    task automatic kick();
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_imem_wdata", 32'(imem_wdata), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
`ifdef PROG_LOADER_ILLEGAL_CHECK_EN
        chk("rst_err", 32'(err), 32'd0);
`endif
    endtask

    // Monitor: every write must match the head of the scoreboard; count tracks pulses since start.
    always @(negedge clk) begin
        if (reset) begin
            mon_count = 0;
        end else begin
            if (imem_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("imem_addr", 32'(imem_addr), 32'(e.addr));
                    chk("imem_wdata", 32'(imem_wdata), 32'(e.data));
                    $display("write addr=%0d data=%04h expected addr=%0d data=%04h",
                             imem_addr, imem_wdata, e.addr, e.data);
                end
                mon_count++;
            end
            chk("count", 32'(count), 32'(mon_count));
            if (start) mon_count = 0;
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_opcode = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_funct = '0; in_imm = '0; in_target = '0;
        #12;
        chk_reset_outputs();
        @(negedge clk);
        #1 reset = 1'b0;

        // valid while idle is ignored
        step(1'b0, 1'b1, 1'b0, 1, 1, 1, 1, 1, 1, 1);

        // basic program: addi, R-type, jump(last)
        kick();
        beat(1, 1, 2, 0, 0, 5, 0, 1'b0);
        beat(0, 1, 2, 3, 4, 0, 0, 1'b0);
        beat(5, 0, 0, 0, 0, 0, 'h12, 1'b1);
        idle(2);

        // fill to DEPTH with continuous valid and no last
        kick();
        for (int i = 0; i < DEPTH + 5; i++)
            beat($urandom_range(0, 5), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 127),
                 $urandom_range(0, 8191), 1'b0);
        idle(2);

        // start collides with a beat at ptr=2
        kick();
        beat(3, 2, 3, 0, 0, 9, 0, 1'b0);
        beat(4, 1, 1, 0, 0, 3, 0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 2, 4, 4, 0, 0, 7, 0);
        beat(1, 6, 5, 0, 0, 100, 0, 1'b1);
        idle(2);

        // reset while the second of three beats is pending
        kick();
        beat(1, 1, 2, 0, 0, 5, 0, 1'b0);
        beat(0, 1, 2, 3, 4, 0, 0, 1'b0);
        #1;
        reset = 1'b1; in_valid = 1'b0;
        exp_q.delete();
        mst = M_IDLE; mptr = 0; err_pend = 1'b0;
        #1;
        chk_reset_outputs();
        @(posedge clk);
        #2;
        chk_reset_outputs();
        @(negedge clk);
        #1 reset = 1'b0;
        step(1'b0, 1'b1, 1'b1, 5, 0, 0, 0, 0, 0, 3);
        kick();
        beat(5, 0, 0, 0, 0, 0, 'h1abc, 1'b1);
        idle(2);

        // boundary field values and opcode 111
        kick();
        beat(4, 7, 7, 0, 0, 'h7f, 0, 1'b0);
        beat(2, 0, 5, 0, 0, 0, 0, 1'b0);
        beat(7, 1, 2, 3, 4, 0, 0, 1'b0);
        beat(6, 7, 0, 7, 15, 0, 0, 1'b1);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit st;
            st = ($urandom_range(0, 39) == 0) || (mst != M_LOAD && $urandom_range(0, 3) == 0);
            step(st, $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 127),
                 $urandom_range(0, 8191));
        end
        idle(3);
        chk("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
